ex_mem_stage: RTL
=================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL expose, in order: CLK in 1, positive-edge clock; nRST in 1, asynchronous active-low reset.
REQ-002 SHALL take from EX: result_EX in word_t (ALU result / dmem address); store_data_EX in word_t; dREN_EX, dWEN_EX, WEN_EX, halt_EX in 1 each; reg_dest_EX in reg_dest_mux_selection; Rt_EX, Rd_EX in regbits_t.
REQ-003 SHALL take from the hazard unit: enable_EX_MEM in 1 (advance request) and flush_EX_MEM in 1 (bubble insert).
REQ-004 SHALL exchange with the dcache: dhit in 1; dmemload_in in word_t; dmemREN, dmemWEN out 1 each; dmemaddr, dmemstore out word_t.
REQ-005 SHALL drive to MEM/WB: result_EX_MEM, dmemload out word_t; WEN_EX_MEM, halt_EX_MEM out 1 each; reg_dest_EX_MEM out reg_dest_mux_selection; Rt_EX_MEM, Rd_EX_MEM out regbits_t.
REQ-006 SHALL drive mem_stall out 1 to the hazard unit (freeze all earlier stages).

Function
REQ-007 Pipeline register SHALL load all EX inputs on the clock edge where load = enable_EX_MEM & ~mem_stall & ~flush_EX_MEM; otherwise it holds its contents.
REQ-008 flush_EX_MEM SHALL take priority over enable: next edge clears every control bit (dREN, dWEN, WEN, halt) to 0, data fields to 0, reg_dest to its enum default.
REQ-009 Request FSM SHALL have states IDLE, WAIT, DONE; reset state IDLE.
REQ-010 IDLE -> WAIT on a load edge whose loaded dREN_EX | dWEN_EX = 1; otherwise stays IDLE.
REQ-011 WAIT: dmemREN/dmemWEN = latched dREN/dWEN; dmemaddr = result_EX_MEM; dmemstore = latched store data; mem_stall = ~dhit.
REQ-012 WAIT with dhit = 1: dmemload register SHALL capture dmemload_in that edge; next state DONE.
REQ-013 DONE: dmemREN = dmemWEN = 0 (no re-issue); mem_stall = 0; on a load edge goes WAIT if the new instruction is a memory op, else IDLE.
REQ-014 IDLE -> WAIT and DONE -> WAIT SHALL not assert mem_stall before the cycle in which WAIT is entered (1-cycle earliest request latency after load).
REQ-015 flush_EX_MEM in any state SHALL force IDLE and drop dmemREN/dmemWEN the following cycle; a pending store in WAIT is abandoned.
REQ-016 halt_EX_MEM SHALL be sticky: once 1 it remains 1 until reset, and no further dmem requests are issued (FSM forced IDLE).
REQ-017 dmemREN and dmemWEN SHALL never be simultaneously 1; if both latched, dWEN wins.
REQ-018 dmemload SHALL hold its last captured value until the next dhit in WAIT.

Reset
REQ-019 nRST low SHALL asynchronously set FSM to IDLE and every output/register to 0 (reg_dest to enum default, mem_stall 0, halt_EX_MEM 0).
REQ-020 Reset asserted mid-WAIT SHALL drop dmemREN/dmemWEN immediately (asynchronously).

Structure
REQ-021 word_t, regbits_t SHALL come from cpu_types_pkg; reg_dest_mux_selection and the new mem_req_state_t enum (IDLE, WAIT, DONE) SHALL live in data_path_muxs_pkg.
REQ-022 The FSM plus dmemload capture SHALL be one sub-module, mem_req_fsm; the pipeline register stays in ex_mem_stage.
REQ-023 Port set SHALL be grouped in a new interface ex_mem_stage_if with modport ex_mem_stage.

Verification
REQ-024 Load, result_EX=0x0000_0040, dREN_EX=1, dhit low 3 cycles then high with dmemload_in=0xDEAD_BEEF -> mem_stall high 3 cycles, dmemload=0xDEAD_BEEF, FSM DONE, dmemREN low next cycle.
REQ-025 Store, result_EX=0x80, store_data_EX=0x1234_5678, dhit on first WAIT cycle -> dmemWEN 1 for one cycle, dmemstore=0x1234_5678, mem_stall never high after dhit.
REQ-026 DONE with enable_EX_MEM=0 for 4 cycles -> no dmemREN/dmemWEN re-assert, outputs held.
REQ-027 flush_EX_MEM with enable_EX_MEM=1 in WAIT -> next cycle IDLE, WEN_EX_MEM=0, dmemREN=0.
REQ-028 halt_EX=1 loaded, then dREN_EX=1 instruction offered -> halt_EX_MEM stays 1, dmemREN never asserts.
REQ-029 nRST pulsed low mid-WAIT -> all outputs 0 within same cycle, FSM IDLE after release.

Source files
------------

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : cpu_types_pkg                                             |
// | Purpose  : Basic datapath widths and types shared across the CPU.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

endpackage
`default_nettype wire

// File: rtl/data_path_muxs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : data_path_muxs_pkg                                        |
// | Purpose  : Datapath mux selections and the memory-request FSM state  |
// |            encoding used by the EX/MEM stage.                        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package data_path_muxs_pkg;

  // Writeback destination register select; REGDEST_RD is the reset/bubble value.
  typedef enum logic [1:0] {
    REGDEST_RD = 2'd0,
    REGDEST_RT = 2'd1,
    REGDEST_RA = 2'd2
  } reg_dest_mux_selection;

  // Data-memory request sequencing.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_req_state_t;

endpackage
`default_nettype wire

// File: rtl/ex_mem_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : ex_mem_stage_if                                          |
// | Purpose   : Groups every EX/MEM stage signal except clock and reset. |
// | Ports     : EX inputs, hazard-unit controls, dcache handshake,       |
// |             MEM/WB outputs and mem_stall.                            |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
interface ex_mem_stage_if;
  import cpu_types_pkg::*;
  import data_path_muxs_pkg::*;

  // From EX
  word_t                 result_EX;
  word_t                 store_data_EX;
  logic                  dREN_EX;
  logic                  dWEN_EX;
  logic                  WEN_EX;
  logic                  halt_EX;
  reg_dest_mux_selection reg_dest_EX;
  regbits_t              Rt_EX;
  regbits_t              Rd_EX;
  // Hazard unit
  logic                  enable_EX_MEM;
  logic                  flush_EX_MEM;
  logic                  mem_stall;
  // Dcache
  logic                  dhit;
  word_t                 dmemload_in;
  logic                  dmemREN;
  logic                  dmemWEN;
  word_t                 dmemaddr;
  word_t                 dmemstore;
  // To MEM/WB
  word_t                 result_EX_MEM;
  word_t                 dmemload;
  logic                  WEN_EX_MEM;
  logic                  halt_EX_MEM;
  reg_dest_mux_selection reg_dest_EX_MEM;
  regbits_t              Rt_EX_MEM;
  regbits_t              Rd_EX_MEM;

  modport ex_mem_stage (
    input  result_EX, store_data_EX, dREN_EX, dWEN_EX, WEN_EX, halt_EX,
           reg_dest_EX, Rt_EX, Rd_EX, enable_EX_MEM, flush_EX_MEM,
           dhit, dmemload_in,
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
           result_EX_MEM, dmemload, WEN_EX_MEM, halt_EX_MEM,
           reg_dest_EX_MEM, Rt_EX_MEM, Rd_EX_MEM, mem_stall
  );

endinterface
`default_nettype wire

// File: rtl/mem_req_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mem_req_fsm                                               |
// | Purpose  : Sequences one dcache request per memory instruction held  |
// |            in the EX/MEM register and captures the load data.        |
// | Ports    : CLK, nRST         - clock, async active-low reset         |
// |            i_load            - EX/MEM register advances this edge    |
// |            i_flush           - bubble insert                         |
// |            i_halt            - CPU halted (or halting this edge)     |
// |            i_mem_op_in       - incoming instruction is a memory op   |
// |            i_dren_q/i_dwen_q - latched read/write enables            |
// |            i_dhit, i_dmemload_in - dcache response                   |
// |            o_dmemREN/o_dmemWEN, o_mem_stall, o_dmemload              |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module mem_req_fsm
  import cpu_types_pkg::*;
  import data_path_muxs_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  i_load,
  input  logic  i_flush,
  input  logic  i_halt,
  input  logic  i_mem_op_in,
  input  logic  i_dren_q,
  input  logic  i_dwen_q,
  input  logic  i_dhit,
  input  word_t i_dmemload_in,
  output logic  o_dmemREN,
  output logic  o_dmemWEN,
  output logic  o_mem_stall,
  output word_t o_dmemload
);

  mem_req_state_t r_state;
  word_t          r_dmemload;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_dmemload <= '0;
    end else begin
      if (r_state == WAIT && i_dhit)
        r_dmemload <= i_dmemload_in;

      if (i_flush || i_halt) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE, DONE: begin
            if (i_load)
              r_state <= i_mem_op_in ? WAIT : IDLE;
          end
          WAIT: begin
            // On the hit edge the pipeline is unstalled and may advance at the
            // same time; the new instruction then must be tracked instead of
            // parking in DONE, otherwise its request would be lost.
            if (i_dhit) begin
              if (i_load)
                r_state <= i_mem_op_in ? WAIT : IDLE;
              else
                r_state <= DONE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Decoded from registered state and latched enables only, so an async reset
  // drops the request immediately. A write wins if both enables were latched.
  assign o_dmemWEN   = (r_state == WAIT) && i_dwen_q;
  assign o_dmemREN   = (r_state == WAIT) && i_dren_q && !i_dwen_q;
  // Must react to dhit within the cycle, hence combinational.
  assign o_mem_stall = (r_state == WAIT) && !i_dhit;
  assign o_dmemload  = r_dmemload;

endmodule
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ex_mem_stage                                              |
// | Purpose  : EX/MEM pipeline register plus the dcache request path.    |
// | Ports    : CLK   - positive-edge clock                               |
// |            nRST  - asynchronous active-low reset                     |
// |            exmif - ex_mem_stage_if.ex_mem_stage (EX inputs, hazard   |
// |                    controls, dcache handshake, MEM/WB outputs,       |
// |                    mem_stall)                                        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module ex_mem_stage
  import cpu_types_pkg::*;
  import data_path_muxs_pkg::*;
(
  input  logic                 CLK,
  input  logic                 nRST,
  ex_mem_stage_if.ex_mem_stage exmif
);

  word_t                 r_result;
  word_t                 r_store_data;
  logic                  r_dren;
  logic                  r_dwen;
  logic                  r_wen;
  logic                  r_halt;
  reg_dest_mux_selection r_reg_dest;
  regbits_t              r_rt;
  regbits_t              r_rd;

  logic                  w_load;
  logic                  w_mem_stall;
  logic                  w_halt;

  assign w_load = exmif.enable_EX_MEM && !w_mem_stall && !exmif.flush_EX_MEM;
  // Halting takes effect on the very edge a halt instruction is latched.
  assign w_halt = r_halt || (w_load && exmif.halt_EX);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_result     <= '0;
      r_store_data <= '0;
      r_dren       <= 1'b0;
      r_dwen       <= 1'b0;
      r_wen        <= 1'b0;
      r_halt       <= 1'b0;
      r_reg_dest   <= REGDEST_RD;
      r_rt         <= '0;
      r_rd         <= '0;
    end else if (exmif.flush_EX_MEM) begin
      // Bubble; halt is left alone because once set it is only cleared by reset.
      r_result     <= '0;
      r_store_data <= '0;
      r_dren       <= 1'b0;
      r_dwen       <= 1'b0;
      r_wen        <= 1'b0;
      r_reg_dest   <= REGDEST_RD;
      r_rt         <= '0;
      r_rd         <= '0;
    end else if (w_load) begin
      r_result     <= exmif.result_EX;
      r_store_data <= exmif.store_data_EX;
      r_dren       <= exmif.dREN_EX;
      r_dwen       <= exmif.dWEN_EX;
      r_wen        <= exmif.WEN_EX;
      r_halt       <= r_halt || exmif.halt_EX;
      r_reg_dest   <= exmif.reg_dest_EX;
      r_rt         <= exmif.Rt_EX;
      r_rd         <= exmif.Rd_EX;
    end
  end

  mem_req_fsm u_fsm (
    .CLK           (CLK),
    .nRST          (nRST),
    .i_load        (w_load),
    .i_flush       (exmif.flush_EX_MEM),
    .i_halt        (w_halt),
    .i_mem_op_in   (exmif.dREN_EX || exmif.dWEN_EX),
    .i_dren_q      (r_dren),
    .i_dwen_q      (r_dwen),
    .i_dhit        (exmif.dhit),
    .i_dmemload_in (exmif.dmemload_in),
    .o_dmemREN     (exmif.dmemREN),
    .o_dmemWEN     (exmif.dmemWEN),
    .o_mem_stall   (w_mem_stall),
    .o_dmemload    (exmif.dmemload)
  );

  assign exmif.mem_stall       = w_mem_stall;
  assign exmif.dmemaddr        = r_result;
  assign exmif.dmemstore       = r_store_data;
  assign exmif.result_EX_MEM   = r_result;
  assign exmif.WEN_EX_MEM      = r_wen;
  assign exmif.halt_EX_MEM     = r_halt;
  assign exmif.reg_dest_EX_MEM = r_reg_dest;
  assign exmif.Rt_EX_MEM       = r_rt;
  assign exmif.Rd_EX_MEM       = r_rd;

endmodule
`default_nettype wire
